// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported SRAM between the instruction-fetch port and the
//   MEM-stage data port. One access is in flight at a time. Simultaneous
//   requests in IDLE are resolved round-robin. A stalled SRAM access is
//   abandoned after MAX_WAIT cycles and completes with 32'hDEADBEEF read data;
//   the sticky timeout_err flag records that this happened.
//
// Ports
//   clk, rst                    clock, asynchronous active-low reset
//   if_req, if_addr             fetch request (held until if_ready), address
//   if_rdata, if_ready          fetched word, one-cycle completion pulse
//   mem_r_en, mem_w_en          data read / write request (held until mem_ready)
//   mem_addr, mem_wdata         data address and store data
//   mem_rdata, mem_ready        load data, one-cycle completion pulse
//   sram_req, sram_we           shared-memory request and write strobe
//   sram_addr, sram_wdata       shared-memory address and write data
//   sram_rdata, sram_ack        memory read data and completion (same cycle)
//   freeze                      pipeline stall request (combinational)
//   timeout_err                 sticky timeout flag

module mem_arbiter #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        sram_req,
   output logic        sram_we,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata,
   input  logic        sram_ack,
   output logic        freeze,
   output logic        timeout_err
);

   localparam int unsigned CW = (MAX_WAIT < 16) ? 4 : $clog2(MAX_WAIT + 1);
   // Last BUSY cycle index: reaching MAX_WAIT happens on the edge that leaves.
   localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_BUSY_D = 2'd1;
   localparam logic [1:0] S_BUSY_I = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   logic [1:0]    r_state;
   logic          r_last_data;   // 1: data port was granted last, 0: fetch
   logic [CW-1:0] r_wait_cnt;
   logic          r_sram_req;
   logic          r_sram_we;
   logic [31:0]   r_sram_addr;
   logic [31:0]   r_sram_wdata;
   logic [31:0]   r_if_rdata;
   logic [31:0]   r_mem_rdata;
   logic          r_if_ready;
   logic          r_mem_ready;
   logic          r_timeout;

   logic          w_data_req;
   logic          w_grant_data;
   logic          w_grant_if;
   logic          w_busy;
   logic          w_finish;
   logic          w_expire;
   logic [31:0]   w_rdata;

   assign w_data_req   = mem_r_en | mem_w_en;
   // Data wins unless fetch also asks and data was the previous winner.
   assign w_grant_data = w_data_req & (~if_req | ~r_last_data);
   assign w_grant_if   = if_req & ~w_grant_data;
   assign w_busy       = (r_state == S_BUSY_D) | (r_state == S_BUSY_I);
   // An ack on the limit cycle still counts as a successful access.
   assign w_finish     = w_busy & (sram_ack | (r_wait_cnt == LIMIT));
   assign w_expire     = w_busy & ~sram_ack & (r_wait_cnt == LIMIT);
   assign w_rdata      = sram_ack ? sram_rdata : 32'hDEADBEEF;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_last_data  <= 1'b0;
         r_wait_cnt   <= '0;
         r_sram_req   <= 1'b0;
         r_sram_we    <= 1'b0;
         r_sram_addr  <= '0;
         r_sram_wdata <= '0;
         r_if_rdata   <= '0;
         r_mem_rdata  <= '0;
         r_if_ready   <= 1'b0;
         r_mem_ready  <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_if_ready  <= 1'b0;
         r_mem_ready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant_data) begin
                  r_state      <= S_BUSY_D;
                  r_last_data  <= 1'b1;
                  r_wait_cnt   <= '0;
                  r_sram_req   <= 1'b1;
                  r_sram_we    <= mem_w_en;
                  r_sram_addr  <= mem_addr;
                  r_sram_wdata <= mem_wdata;
               end else if (w_grant_if) begin
                  r_state      <= S_BUSY_I;
                  r_last_data  <= 1'b0;
                  r_wait_cnt   <= '0;
                  r_sram_req   <= 1'b1;
                  r_sram_we    <= 1'b0;
                  r_sram_addr  <= if_addr;
                  r_sram_wdata <= '0;
               end
            end
            S_BUSY_D, S_BUSY_I: begin
               if (!sram_ack) begin
                  r_wait_cnt <= r_wait_cnt + CW'(1);
               end
               if (w_finish) begin
                  r_state    <= S_RESP;
                  r_sram_req <= 1'b0;
                  r_sram_we  <= 1'b0;
                  if (w_expire) begin
                     r_timeout <= 1'b1;
                  end
                  if (r_state == S_BUSY_D) begin
                     r_mem_ready <= 1'b1;
                     // A store leaves the load-data register untouched.
                     if (!r_sram_we) begin
                        r_mem_rdata <= w_rdata;
                     end
                  end else begin
                     r_if_ready <= 1'b1;
                     r_if_rdata <= w_rdata;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign if_rdata    = r_if_rdata;
   assign if_ready    = r_if_ready;
   assign mem_rdata   = r_mem_rdata;
   assign mem_ready   = r_mem_ready;
   assign sram_req    = r_sram_req;
   assign sram_we     = r_sram_we;
   assign sram_addr   = r_sram_addr;
   assign sram_wdata  = r_sram_wdata;
   assign timeout_err = r_timeout;
   assign freeze      = (w_data_req & ~r_mem_ready) | (if_req & ~r_if_ready);

endmodule
